// File: rtl/cvsd_pkg.sv
// ---------------------------------------------------------------------------
// cvsd_pkg
// Shared constants and helpers for the CVSD step-size adapter.
//   CVSD_*          : default parameter values for the adapter
//   MODE_LEGACY/... : encoding of the mode_i input
//   sat_signed()    : clamp a wide signed value into a w-bit signed range
// ---------------------------------------------------------------------------
package cvsd_pkg;

    localparam int CVSD_STEP_MIN = 10;
    localparam int CVSD_STEP_MAX = 1280;
    localparam int CVSD_STEP_INC = 10;
    localparam int CVSD_FRAC_W   = 10;
    localparam int CVSD_DECAY_SH = 10;

    localparam logic MODE_LEGACY = 1'b0;  // grow on every '1'
    localparam logic MODE_COINC  = 1'b1;  // grow on run-of-N coincidence

    // Clamp v to [-2^(w-1), 2^(w-1)-1]; w is expected to be a constant.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/cvsd_step_adapt_if.sv
// ---------------------------------------------------------------------------
// cvsd_step_adapt_if
// Bit-stream and result bundle of the CVSD step adapter.
//   enable_i/data_i/mode_i/clear_i : driven by the bit source (master)
//   step_o/est_o/coinc_o/valid_o   : driven by the adapter (slave)
// Handshake: there is no backpressure. A bit is taken on every rising clock
// edge where enable_i=1 and clear_i=0; valid_o is high for exactly the next
// cycle, during which step_o/est_o/coinc_o show the result of that bit.
// Outside valid_o the outputs hold their last value.
// ---------------------------------------------------------------------------
interface cvsd_step_adapt_if #(
    parameter int STEP_W = 16,
    parameter int ACC_W  = 16
);
    logic                     enable_i;
    logic                     data_i;
    logic                     mode_i;
    logic                     clear_i;
    logic [STEP_W-1:0]        step_o;
    logic signed [ACC_W-1:0]  est_o;
    logic                     coinc_o;
    logic                     valid_o;

    modport master (
        output enable_i, data_i, mode_i, clear_i,
        input  step_o, est_o, coinc_o, valid_o
    );

    modport slave (
        input  enable_i, data_i, mode_i, clear_i,
        output step_o, est_o, coinc_o, valid_o
    );
endinterface

// File: rtl/cvsd_run_detect.sv
// ---------------------------------------------------------------------------
// cvsd_run_detect
// Tracks the last RUN_LEN-1 accepted bits and how many bits have arrived
// since reset/clear. coinc_o is combinational: it says whether the bit now on
// data_i would complete a run of RUN_LEN identical bits.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : sync clear (wins over enable_i)
//   enable_i      : accept data_i at this edge
//   data_i        : incoming CVSD bit
//   coinc_o       : run-of-RUN_LEN coincidence for the incoming bit
// ---------------------------------------------------------------------------
module cvsd_run_detect #(
    parameter int RUN_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    input  logic data_i,
    output logic coinc_o
);
    localparam int FW = $clog2(RUN_LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(RUN_LEN - 1);

    logic [RUN_LEN-2:0] r_hist;
    logic [FW-1:0]      r_fill;
    logic [RUN_LEN-1:0] w_hist_next;
    logic               w_full;

    assign w_hist_next = {r_hist, data_i};
    // Until RUN_LEN-1 bits are stored, stale zeros in r_hist must not count.
    assign w_full      = (r_fill == FILL_MAX);
    assign coinc_o     = w_full && ((&w_hist_next) || !(|w_hist_next));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (clear_i) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (enable_i) begin
            r_hist <= w_hist_next[RUN_LEN-2:0];
            if (!w_full)
                r_fill <= r_fill + FW'(1);
        end
    end
endmodule

// File: rtl/cvsd_step_adapt.sv
// ---------------------------------------------------------------------------
// cvsd_step_adapt
// CVSD syllabic step-size adapter with integrator. Each accepted bit either
// grows the step by STEP_INC (capped at STEP_MAX) or decays it by
// step>>DECAY_SH (floored at STEP_MIN), keeping FRAC_W fraction bits so slow
// decay is not lost to truncation. The integer step is then added to or
// subtracted from the saturating PCM estimate.
//   clk_i, rst_ni : clock, async active-low reset
//   bus           : slave side of cvsd_step_adapt_if (bit in, step/est out)
// ---------------------------------------------------------------------------
module cvsd_step_adapt
    import cvsd_pkg::*;
#(
    parameter int STEP_W   = 16,
    parameter int FRAC_W   = CVSD_FRAC_W,
    parameter int ACC_W    = 16,
    parameter int RUN_LEN  = 3,
    parameter int STEP_MIN = CVSD_STEP_MIN,
    parameter int STEP_MAX = CVSD_STEP_MAX,
    parameter int STEP_INC = CVSD_STEP_INC,
    parameter int DECAY_SH = CVSD_DECAY_SH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    cvsd_step_adapt_if.slave  bus
);
    // One spare bit above the step register so the grow sum never wraps.
    localparam int QW = STEP_W + FRAC_W;
    localparam int SW = QW + 1;
    localparam logic [SW-1:0] STEP_MIN_F = SW'(STEP_MIN) << FRAC_W;
    localparam logic [SW-1:0] STEP_MAX_F = SW'(STEP_MAX) << FRAC_W;
    localparam logic [SW-1:0] STEP_INC_F = SW'(STEP_INC) << FRAC_W;
    localparam logic [QW-1:0] STEP_RST   = STEP_MIN_F[QW-1:0];

    logic [QW-1:0]           r_step;
    logic signed [ACC_W-1:0] r_est;
    logic                    r_coinc;
    logic                    r_valid;

    logic                    w_coinc;
    logic                    w_grow;
    logic [SW-1:0]           w_step_ext;
    logic [SW-1:0]           w_step_up;
    logic [SW-1:0]           w_step_dn;
    logic [SW-1:0]           w_step_nxt;
    logic [STEP_W-1:0]       w_step_int;
    logic signed [63:0]      w_est_sum;
    logic signed [63:0]      w_est_sat;

    cvsd_run_detect #(.RUN_LEN(RUN_LEN)) u_run (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (bus.clear_i),
        .enable_i (bus.enable_i),
        .data_i   (bus.data_i),
        .coinc_o  (w_coinc)
    );

    always_comb begin
        w_grow     = (bus.mode_i == MODE_COINC) ? w_coinc : bus.data_i;
        w_step_ext = {1'b0, r_step};
        w_step_up  = w_step_ext + STEP_INC_F;
        if (w_step_up > STEP_MAX_F)
            w_step_up = STEP_MAX_F;
        w_step_dn  = w_step_ext - (w_step_ext >> DECAY_SH);
        if (w_step_dn < STEP_MIN_F)
            w_step_dn = STEP_MIN_F;
        w_step_nxt = w_grow ? w_step_up : w_step_dn;
        w_step_int = w_step_nxt[QW-1:FRAC_W];
        // Integrate with the freshly adapted step, not the previous one.
        if (bus.data_i)
            w_est_sum = 64'(r_est) + 64'($signed({1'b0, w_step_int}));
        else
            w_est_sum = 64'(r_est) - 64'($signed({1'b0, w_step_int}));
        w_est_sat  = sat_signed(w_est_sum, ACC_W);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_step  <= STEP_RST;
            r_est   <= '0;
            r_coinc <= 1'b0;
            r_valid <= 1'b0;
        end else if (bus.clear_i) begin
            r_step  <= STEP_RST;
            r_est   <= '0;
            r_coinc <= 1'b0;
            r_valid <= 1'b0;
        end else if (bus.enable_i) begin
            r_step  <= w_step_nxt[QW-1:0];
            r_est   <= w_est_sat[ACC_W-1:0];
            r_coinc <= w_coinc;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign bus.step_o  = r_step[QW-1:FRAC_W];
    assign bus.est_o   = r_est;
    assign bus.coinc_o = r_coinc;
    assign bus.valid_o = r_valid;
endmodule

// File: tb/tb_cvsd_step_adapt.sv
// ---------------------------------------------------------------------------
// tb_cvsd_step_adapt
// Directed bench for cvsd_step_adapt. A reference model in plain integer
// arithmetic tracks the expected outputs; a negedge process compares every
// cycle, and literal expectations pin key points of the model.
// ---------------------------------------------------------------------------
module tb_cvsd_step_adapt;
    localparam int STEP_W   = 16;
    localparam int ACC_W    = 16;
    localparam int RUN_LEN  = 3;
    localparam longint ONE  = 1024;          // 2^FRAC_W
    localparam longint SMIN = 10 * ONE;
    localparam longint SMAX = 1280 * ONE;
    localparam longint SINC = 10 * ONE;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cvsd_step_adapt_if #(.STEP_W(STEP_W), .ACC_W(ACC_W)) bus ();

    cvsd_step_adapt dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint m_step_f;   // step scaled by 2^FRAC_W
    longint m_est;
    bit     m_coinc;
    bit     m_valid;
    bit     m_bits[$];  // most recent accepted bits since reset/clear

    function automatic void model_reset();
        m_step_f = SMIN;
        m_est    = 0;
        m_coinc  = 1'b0;
        m_valid  = 1'b0;
        m_bits.delete();
    endfunction

    function automatic void model_apply(input bit en, input bit d, input bit mode, input bit clr);
        bit grow;
        bit all_same;
        longint s;
        if (clr) begin
            model_reset();
            return;
        end
        if (!en) begin
            m_valid = 1'b0;
            return;
        end
        m_bits.push_back(d);
        if (m_bits.size() > RUN_LEN)
            void'(m_bits.pop_front());
        all_same = 1'b1;
        foreach (m_bits[i])
            if (m_bits[i] != d) all_same = 1'b0;
        m_coinc = (m_bits.size() == RUN_LEN) && all_same;
        grow = mode ? m_coinc : d;
        if (grow) begin
            s = m_step_f + SINC;
            m_step_f = (s > SMAX) ? SMAX : s;
        end else begin
            s = m_step_f - m_step_f / ONE;
            m_step_f = (s < SMIN) ? SMIN : s;
        end
        m_est = d ? m_est + m_step_f / ONE : m_est - m_step_f / ONE;
        if (m_est > 32767)  m_est = 32767;
        if (m_est < -32768) m_est = -32768;
        m_valid = 1'b1;
    endfunction

    // Single compare process: outputs are checked every cycle once out of reset.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_valid", longint'(bus.valid_o), longint'(m_valid));
            check("cyc_step",  longint'(bus.step_o),  m_step_f / ONE);
            check("cyc_est",   longint'(bus.est_o),   m_est);
            check("cyc_coinc", longint'(bus.coinc_o), longint'(m_coinc));
        end
    end

    // ---------------- driver ----------------
    task automatic send(input bit en, input bit d, input bit mode, input bit clr);
        bus.enable_i = en;
        bus.data_i   = d;
        bus.mode_i   = mode;
        bus.clear_i  = clr;
        @(posedge clk);
        #1;
        model_apply(en, d, mode, clr);
    endtask

    task automatic pulse_reset();
        // Asynchronous: outputs must change without waiting for a clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_step",  longint'(bus.step_o),  10);
        check("areset_est",   longint'(bus.est_o),   0);
        check("areset_valid", longint'(bus.valid_o), 0);
        check("areset_coinc", longint'(bus.coinc_o), 0);
        model_reset();
        #4;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    bit     t4_bits[4]  = '{1, 1, 1, 0};
    longint t4_step[4]  = '{10, 10, 20, 19};
    longint t4_coinc[4] = '{0, 0, 1, 0};
    longint t4_est[4]   = '{10, 20, 40, 21};
    bit     t6_en[5]    = '{1, 0, 0, 1, 1};

    initial begin
        bus.enable_i = 1'b0;
        bus.data_i   = 1'b0;
        bus.mode_i   = 1'b0;
        bus.clear_i  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;

        // 1: idle after reset
        repeat (3) send(0, 0, 0, 0);
        check("t1_step",  longint'(bus.step_o),  10);
        check("t1_est",   longint'(bus.est_o),   0);
        check("t1_valid", longint'(bus.valid_o), 0);
        check("t1_coinc", longint'(bus.coinc_o), 0);

        // 2: legacy mode, 130 ones
        for (int i = 1; i <= 130; i++) begin
            send(1, 1, 0, 0);
            if (i == 1)   check("t2_step1",   longint'(bus.step_o), 20);
            if (i == 2)   check("t2_step2",   longint'(bus.step_o), 30);
            if (i == 126) check("t2_step126", longint'(bus.step_o), 1270);
            if (i == 127) check("t2_step127", longint'(bus.step_o), 1280);
        end
        check("t2_step_hold", longint'(bus.step_o), 1280);
        check("t2_est_sat",   longint'(bus.est_o),  32767);

        // 3: decay from the ceiling
        send(1, 0, 0, 0);
        check("t3_step_first", longint'(bus.step_o), 1278);
        check("t3_est_first",  longint'(bus.est_o),  32767 - 1278);
        for (int i = 0; i < 6000; i++)
            send(1, 0, 0, 0);
        check("t3_step_floor", longint'(bus.step_o), 10);
        check("t3_est_floor",  longint'(bus.est_o),  -32768);

        // 4: coincidence mode after reset
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            send(1, t4_bits[i], 1, 0);
            check("t4_step",  longint'(bus.step_o),  t4_step[i]);
            check("t4_coinc", longint'(bus.coinc_o), t4_coinc[i]);
            check("t4_est",   longint'(bus.est_o),   t4_est[i]);
        end

        // 5: clear mid-stream, then async reset mid-cycle
        send(0, 0, 0, 1);
        for (int i = 0; i < 49; i++)
            send(1, 1, 0, 0);
        check("t5_step500", longint'(bus.step_o), 500);
        send(1, 1, 0, 1);
        check("t5_clr_step",  longint'(bus.step_o),  10);
        check("t5_clr_est",   longint'(bus.est_o),   0);
        check("t5_clr_valid", longint'(bus.valid_o), 0);
        for (int i = 0; i < 5; i++)
            send(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        send(1, 1, 0, 0);
        pulse_reset();

        // 6: gapped enables, outputs hold during gaps
        for (int i = 0; i < 5; i++) begin
            send(t6_en[i], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            check("t6_valid", longint'(bus.valid_o), longint'(t6_en[i]));
        end
        for (int i = 0; i < 200; i++)
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
        send(0, 0, 0, 0);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cvsd_step_adapt.md
Name: cvsd_step_adapt

Overview:
- Parametrised CVSD syllabic step-size adapter with a built-in integrator, shared by the CVSD encoder and decoder paths.
- Consumes one CVSD bit per enable strobe and updates the step size.
- Step update is either legacy-style (grow on every '1') or run-of-N coincidence.
- Retains fractional decay precision and produces the saturated PCM estimate.

Parameters:
STEP_W, 16, integer width of step size
FRAC_W, 10, fraction bits kept in step register
ACC_W, 16, signed integrator (PCM estimate) width
RUN_LEN, 3, coincidence run length (>=2)
STEP_MIN, 10, step floor (integer)
STEP_MAX, 1280, step ceiling (integer, STEP_MIN<=STEP_MAX<2^STEP_W)
STEP_INC, 10, step increment on grow (integer)
DECAY_SH, 10, decay shift: step -= step>>DECAY_SH (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  bit strobe; data_i consumed when high
data_i  in  1  CVSD bit
mode_i  in  1  0 = grow on data_i=1; 1 = grow on coincidence
clear_i  in  1  synchronous clear, priority over enable_i
step_o  out  STEP_W  current step, integer part, registered
est_o  out  ACC_W  signed PCM estimate, registered
coinc_o  out  1  coincidence flag of last accepted bit
valid_o  out  1  one-cycle pulse: outputs updated

Behaviour:
- Reset (rst_ni=0, async) and clear_i (sync) force the same state:
  - step_q = STEP_MIN<<FRAC_W; step_o=STEP_MIN.
  - est_o=0, hist_q=0, fill_q=0, coinc_o=0, valid_o=0.
- Handling of enable_i=1 at a clock edge, with clear_i=0:
  - h' = {hist_q[RUN_LEN-2:0], data_i}.
  - fill_q increments, saturating at RUN_LEN-1.
  - coinc = (fill_q==RUN_LEN-1) and all bits of h' equal. This means the first RUN_LEN-1 bits after reset or clear can never coincide.
  - grow = mode_i ? coinc : data_i.
  - Grow: step' = min(step_q + (STEP_INC<<FRAC_W), STEP_MAX<<FRAC_W).
  - Else: step' = max(step_q - (step_q>>DECAY_SH), STEP_MIN<<FRAC_W).
  - All step arithmetic is done in STEP_W+FRAC_W+1 bits; the sum never wraps.
  - Integer part is floor: step'[STEP_W+FRAC_W-1:FRAC_W].
  - est' = est_o + (data_i ? +int(step') : -int(step')), computed in ACC_W+1 bits.
  - est' saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - step_q, hist_q, fill_q, est_o, coinc_o are registered at that edge.
- Latency: outputs reflect a bit one cycle after its enable edge.
  - valid_o=1 for exactly the cycle following each accepted edge.
  - Back-to-back enables give continuous valid_o.
- enable_i=0: all state holds; valid_o=0.
- clear_i=1 with enable_i=1: clear wins; the bit is dropped and valid_o=0 next cycle.
- mode_i may change between bits and is sampled only on accepted edges. history and fill are unaffected by mode changes.
- Step stays within [STEP_MIN, STEP_MAX] at all times.

Decomposition:
- Package cvsd_pkg holds:
  - default constants: CVSD_STEP_MIN, CVSD_STEP_MAX, CVSD_STEP_INC, CVSD_FRAC_W, CVSD_DECAY_SH.
  - mode encoding localparams: MODE_LEGACY=0, MODE_COINC=1.
  - a signed saturation function.
- One sub-module: cvsd_run_detect.
  - Contains the history shift register and fill counter.
  - Parameter RUN_LEN; outputs coinc combinationally from the incoming bit.
  - Shares clk_i, rst_ni, clear_i.

Test Plan:
1. Reset, then release with no enable -> step_o=10, est_o=0, valid_o=0, coinc_o=0 held.
2. mode_i=0, 130 consecutive '1' bits:
   - step_o=20, 30, … after each bit; 1280 after the 127th bit, and it stays at 1280.
   - est_o saturates at 32767 and does not wrap.
3. From step 1280, mode_i=0, one '0' bit -> step_o=1278 (1309440>>10), est_o decreases by 1278. Continue with '0' bits -> step decays monotonically and settles at 10.
4. After reset, mode_i=1, bits 1,1,1,0:
   - step_o=10, 10, 20, 19.
   - coinc_o=0, 0, 1, 0.
   - est_o=10, 20, 40, 21.
5. clear_i asserted together with enable_i mid-stream (step=500) -> next cycle step_o=10, est_o=0, valid_o=0. rst_ni pulsed low between clock edges -> outputs reset immediately.
6. Enable pattern 1,0,0,1,1 -> valid_o pulses one cycle after each strobe, including back-to-back. Outputs hold during gaps.
